// File: rtl/conv_icb_arb.sv
// Three-way ICB arbiter for the conv engine: weight loader, input loader, output writer.
// Optional build macro CONV_ICB_ARB_FIXED_PRIO_EN selects fixed priority 2 > 0 > 1 instead of round-robin.
module conv_icb_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req_valid,
  output logic [2:0]        req_ready,
  input  logic [2:0]        req_read,
  input  logic [3*AW-1:0]   req_addr,
  input  logic [3*DW-1:0]   req_wdata,
  output logic [2:0]        rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              busy,
  output logic [1:0]        grant_id,
  output logic              conv_icb_cmd_valid,
  input  logic              conv_icb_cmd_ready,
  output logic [AW-1:0]     conv_icb_cmd_addr,
  output logic              conv_icb_cmd_read,
  output logic [DW-1:0]     conv_icb_cmd_wdata,
  output logic [DW/8-1:0]   conv_icb_cmd_wmask,
  input  logic              conv_icb_rsp_valid,
  output logic              conv_icb_rsp_ready,
  input  logic [DW-1:0]     conv_icb_rsp_rdata
);

  // state | meaning
  // IDLE  | no owner, arbitrate pending req_valid
  // CMD   | command presented on ICB, waiting for cmd_ready
  // RSP   | waiting for the response of the owner
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  logic [1:0] state;
  logic [1:0] win;
  logic       any_req;

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  assign any_req = |req_valid;

`ifdef CONV_ICB_ARB_FIXED_PRIO_EN
  // output drain wins so the writer never starves behind the loaders
  always_comb begin
    win = 2'd1;
    if (req_valid[2])      win = 2'd2;
    else if (req_valid[0]) win = 2'd0;
  end
`else
  logic [1:0] last;
  logic [1:0] c0, c1, c2;

  always_comb begin
    c0 = 2'd0;
    c1 = 2'd1;
    c2 = 2'd2;
    case (last)
      2'd0: begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd1: begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase
    win = c2;
    if (req_valid[c0])      win = c0;
    else if (req_valid[c1]) win = c1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last <= 2'd2;
    else if (state == S_IDLE && any_req)
      last <= win;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      grant_id           <= 2'd3;
      conv_icb_cmd_valid <= 1'b0;
      conv_icb_cmd_addr  <= '0;
      conv_icb_cmd_read  <= 1'b0;
      conv_icb_cmd_wdata <= '0;
      conv_icb_cmd_wmask <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            conv_icb_cmd_valid <= 1'b1;
            conv_icb_cmd_addr  <= req_addr[win*AW +: AW];
            conv_icb_cmd_read  <= req_read[win];
            conv_icb_cmd_wdata <= req_wdata[win*DW +: DW];
            conv_icb_cmd_wmask <= req_read[win] ? '0 : '1;
            grant_id           <= win;
            state              <= S_CMD;
          end
        end
        S_CMD: begin
          if (conv_icb_cmd_ready) begin
            conv_icb_cmd_valid <= 1'b0;
            state              <= S_RSP;
          end
        end
        S_RSP: begin
          if (conv_icb_rsp_valid) begin
            grant_id <= 2'd3;
            state    <= S_IDLE;
          end
        end
        default: begin
          grant_id <= 2'd3;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  assign busy               = (state != S_IDLE);
  assign req_ready          = (state == S_IDLE && any_req) ? onehot(win) : 3'b000;
  assign conv_icb_rsp_ready = (state == S_RSP);
  assign rsp_valid          = (state == S_RSP && conv_icb_rsp_valid) ? onehot(grant_id) : 3'b000;
  assign rsp_rdata          = conv_icb_rsp_rdata;

endmodule

// File: tb/tb_conv_icb_arb.sv
// Bench for conv_icb_arb: table-driven transactions with a cmd/rsp scoreboard plus a reset-in-RSP sequence.
// Compile with CONV_ICB_ARB_FIXED_PRIO_EN to check the fixed-priority build.
module tb_conv_icb_arb;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        req_valid, req_ready, req_read, rsp_valid;
  logic [3*AW-1:0]   req_addr;
  logic [3*DW-1:0]   req_wdata;
  logic [DW-1:0]     rsp_rdata;
  logic              busy;
  logic [1:0]        grant_id;
  logic              cmd_valid, cmd_ready, cmd_read, icb_rsp_valid, icb_rsp_ready;
  logic [AW-1:0]     cmd_addr;
  logic [DW-1:0]     cmd_wdata, icb_rsp_rdata;
  logic [DW/8-1:0]   cmd_wmask;

  conv_icb_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .grant_id(grant_id),
    .conv_icb_cmd_valid(cmd_valid), .conv_icb_cmd_ready(cmd_ready),
    .conv_icb_cmd_addr(cmd_addr), .conv_icb_cmd_read(cmd_read),
    .conv_icb_cmd_wdata(cmd_wdata), .conv_icb_cmd_wmask(cmd_wmask),
    .conv_icb_rsp_valid(icb_rsp_valid), .conv_icb_rsp_ready(icb_rsp_ready),
    .conv_icb_rsp_rdata(icb_rsp_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]        vmask;
    logic [2:0]        rd;
    logic [2:0][31:0]  addr;
    logic [2:0][31:0]  wdata;
    int                dly;
    logic [31:0]       rdata;
    int                exp_g;
  } vec_t;

  typedef struct {
    logic [1:0]  g;
    logic [31:0] addr;
    logic        read;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } cmd_exp_t;

  typedef struct {
    logic [2:0]  oh;
    logic [31:0] rdata;
  } rsp_exp_t;

  cmd_exp_t cmd_q[$];
  rsp_exp_t rsp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] vmask, input int dly,
                              input logic [31:0] rdata, input int exp_g);
    vec_t v;
    v.vmask = vmask;
    v.rd    = 3'b011;
    v.addr  = {32'h6000_0000, 32'h4000_0010, 32'h0000_2000};
    v.wdata = {32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hA5A5_0000};
    v.dly   = dly;
    v.rdata = rdata;
    v.exp_g = exp_g;
    return v;
  endfunction

  task automatic do_txn(input vec_t v);
    cmd_exp_t e;
    rsp_exp_t r;
    int waited;
    @(negedge clk);
    req_valid = v.vmask;
    req_read  = v.rd;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    e.g     = v.exp_g[1:0];
    e.addr  = v.addr[v.exp_g];
    e.read  = v.rd[v.exp_g];
    e.wdata = v.wdata[v.exp_g];
    e.wmask = v.rd[v.exp_g] ? 4'h0 : 4'hF;
    cmd_q.push_back(e);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_grant_id", grant_id, 3);
    chk("idle_cmd_valid", cmd_valid, 0);
    waited = 0;
    while (req_ready == 3'b000 && waited < 8) begin
      @(negedge clk); #1; waited++;
    end
    chk("req_ready", req_ready, 3'b001 << e.g);

    for (int k = 0; k <= v.dly; k++) begin
      @(negedge clk);
      cmd_ready     = (k == v.dly);
      icb_rsp_valid = (k != v.dly);
      icb_rsp_rdata = 32'hBAD0_0000;
      #1;
      if (k == 0) e = cmd_q.pop_front();
      chk("cmd_valid", cmd_valid, 1);
      chk("cmd_addr", cmd_addr, e.addr);
      chk("cmd_read", cmd_read, e.read);
      chk("cmd_wdata", cmd_wdata, e.wdata);
      chk("cmd_wmask", cmd_wmask, e.wmask);
      chk("cmd_grant_id", grant_id, e.g);
      chk("cmd_busy", busy, 1);
      chk("cmd_req_ready", req_ready, 0);
      chk("cmd_rsp_ready", icb_rsp_ready, 0);
      chk("cmd_stray_rsp", rsp_valid, 0);
    end

    @(negedge clk);
    cmd_ready     = 1'b0;
    icb_rsp_valid = 1'b1;
    icb_rsp_rdata = v.rdata;
    r.oh    = 3'b001 << e.g;
    r.rdata = v.rdata;
    rsp_q.push_back(r);
    #1;
    chk("rsp_cmd_valid", cmd_valid, 0);
    chk("rsp_ready", icb_rsp_ready, 1);
    if (rsp_valid != 3'b000) begin
      r = rsp_q.pop_front();
      chk("rsp_valid", rsp_valid, r.oh);
      chk("rsp_rdata", rsp_rdata, r.rdata);
    end else begin
      chk("rsp_valid_missing", rsp_valid, r.oh);
    end
  endtask

  vec_t t1[3];
  vec_t t2[5];

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_read = '0; req_addr = '0; req_wdata = '0;
    cmd_ready = 1'b0; icb_rsp_valid = 1'b0; icb_rsp_rdata = '0;

    t1[0] = mk(3'b001, 0, 32'h1122_3344, 0);
    t1[1] = mk(3'b100, 0, 32'h0000_0000, 2);
    t1[2] = mk(3'b010, 5, 32'hCAFE_0001, 1);
`ifdef CONV_ICB_ARB_FIXED_PRIO_EN
    t2[0] = mk(3'b111, 0, 32'h0000_0010, 2);
    t2[1] = mk(3'b111, 1, 32'h0000_0011, 2);
    t2[2] = mk(3'b111, 0, 32'h0000_0012, 2);
    t2[3] = mk(3'b011, 0, 32'h0000_0013, 0);
    t2[4] = mk(3'b011, 2, 32'h0000_0014, 0);
`else
    t2[0] = mk(3'b111, 0, 32'h0000_0010, 0);
    t2[1] = mk(3'b111, 1, 32'h0000_0011, 1);
    t2[2] = mk(3'b111, 0, 32'h0000_0012, 2);
    t2[3] = mk(3'b011, 0, 32'h0000_0013, 0);
    t2[4] = mk(3'b011, 2, 32'h0000_0014, 1);
`endif

    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    chk("rst_cmd_wmask", cmd_wmask, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 3);
    chk("rst_req_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) do_txn(t1[i]);

    // reset while waiting for a response: the transaction is dropped
    @(negedge clk);
    req_valid = 3'b000; icb_rsp_valid = 1'b0;
    req_valid = 3'b010;
    @(negedge clk);
    req_valid = 3'b000; cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    #1;
    chk("pre_rst_rsp_ready", icb_rsp_ready, 1);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_grant_id", grant_id, 3);
    chk("mid_rst_cmd_valid", cmd_valid, 0);
    chk("mid_rst_cmd_addr", cmd_addr, 0);
    chk("mid_rst_rsp_ready", icb_rsp_ready, 0);
    icb_rsp_valid = 1'b1;
    icb_rsp_rdata = 32'h5555_AAAA;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_rsp_ready", icb_rsp_ready, 0);
    icb_rsp_valid = 1'b0;

    for (int i = 0; i < 5; i++) do_txn(t2[i]);

    @(negedge clk);
    req_valid = 3'b000;
    icb_rsp_valid = 1'b0;
    #1;
    chk("end_busy", busy, 0);
    chk("end_grant_id", grant_id, 3);
    chk("end_cmd_q_empty", cmd_q.size(), 0);
    chk("end_rsp_q_empty", rsp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
